// File: rtl/seg7_capture_if.sv
// Bundles the signals between a multiplexed 7-segment display driver and the
// capture block: the scanned anode/cathode lines towards the block, and the
// decoded frame, pulses and status coming back out of it.
//   master : display driver / observer (drives anodes, cnodes)
//   slave  : seg7_capture (drives data, valid, err, err_cnt, digit_mask)
interface seg7_capture_if #(
  parameter int DIGITS = 8
);
  logic [DIGITS-1:0]   anodes;      // active-low digit select, bit i -> nibble i
  logic [7:0]          cnodes;      // active-low {dp,g,f,e,d,c,b,a}
  logic [4*DIGITS-1:0] data;        // last complete decoded frame
  logic                valid;       // one-cycle pulse when data updates
  logic                err;         // one-cycle pulse per rejected digit
  logic [7:0]          err_cnt;     // rejected digits, saturating at 255
  logic [DIGITS-1:0]   digit_mask;  // digits captured in the current frame

  modport master (
    output anodes, cnodes,
    input  data, valid, err, err_cnt, digit_mask
  );

  modport slave (
    input  anodes, cnodes,
    output data, valid, err, err_cnt, digit_mask
  );
endinterface

// File: rtl/seg7_capture.sv
// Purpose: snoops a multiplexed 7-segment display and rebuilds the hex value shown.
// Latency: digit lands in shadow 1 cycle after its SETTLE-th identical registered sample.
// Backpressure: none; pure observer, frames and errors are one-cycle pulses.
//
// Ports:
//   clk, rst_n : single clock, asynchronous active-low reset
//   bus        : seg7_capture_if slave modport
//                anodes/cnodes in; data, valid, err, err_cnt, digit_mask out
module seg7_capture #(
  parameter int DIGITS = 8,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_capture_if.slave   bus
);

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_COUNT,
    ST_HOLD
  } state_t;

  // Registered copies of the display lines; every decision uses these.
  logic [DIGITS-1:0]   an_q;
  logic [6:0]          seg_q;
  logic                unused_dp;

  // Candidate sample under test and how many times it has been seen in a row.
  logic [DIGITS-1:0]   cand_an_q;
  logic [6:0]          cand_seg_q;
  logic [7:0]          cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic                cand_load;
  logic                eval;

  logic [4*DIGITS-1:0] shadow_q, shadow_nx;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   mask_q, mask_nx;
  logic                valid_q;
  logic                err_q;
  logic [7:0]          err_cnt_q;

  logic [DIGITS-1:0]   lo;
  logic                any_low;
  logic                single_low;
  logic                same;
  logic [7:0]          cnt_inc;
  logic                glyph_hit;
  logic [3:0]          glyph_nib;
  logic                eval_ok;
  logic                eval_bad;
  logic                frame_done;

  // The decimal point never influences capture.
  assign unused_dp = bus.cnodes[7];

  // Input registers reset to all ones so the block starts from a blank display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= '1;
    end else begin
      an_q  <= bus.anodes;
      seg_q <= bus.cnodes[6:0];
    end
  end

  assign lo         = ~an_q;
  assign any_low    = (lo != '0);
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign single_low = any_low && ((lo & (lo - DIGITS'(1))) == '0);
  assign same       = (an_q == cand_an_q) && (seg_q == cand_seg_q);
  assign cnt_inc    = cnt_q + 8'd1;

  // Glyph decode of the active-low segment pattern {g,f,e,d,c,b,a}.
  always_comb begin
    glyph_hit = 1'b1;
    glyph_nib = 4'h0;
    case (seg_q)
      7'h40:   glyph_nib = 4'h0;
      7'h79:   glyph_nib = 4'h1;
      7'h24:   glyph_nib = 4'h2;
      7'h30:   glyph_nib = 4'h3;
      7'h19:   glyph_nib = 4'h4;
      7'h12:   glyph_nib = 4'h5;
      7'h02:   glyph_nib = 4'h6;
      7'h78:   glyph_nib = 4'h7;
      7'h00:   glyph_nib = 4'h8;
      7'h10:   glyph_nib = 4'h9;
      7'h08:   glyph_nib = 4'hA;
      7'h03:   glyph_nib = 4'hB;
      7'h46:   glyph_nib = 4'hC;
      7'h21:   glyph_nib = 4'hD;
      7'h06:   glyph_nib = 4'hE;
      7'h0E:   glyph_nib = 4'hF;
      default: glyph_hit = 1'b0;
    endcase
  end

  // Stability FSM. A run of identical non-blank samples is evaluated once,
  // on its SETTLE-th sample; HOLD then swallows the rest of that strobe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_load = 1'b0;
    eval      = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (any_low) begin
          cand_load = 1'b1;
          cnt_d     = 8'd1;
          state_d   = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (same) begin
          cnt_d = cnt_inc;
          if (cnt_inc == SETTLE_C) begin
            eval    = 1'b1;
            state_d = ST_HOLD;
          end
        end else if (!any_low) begin
          cnt_d   = 8'd0;
          state_d = ST_WAIT;
        end else begin
          cand_load = 1'b1;
          cnt_d     = 8'd1;
        end
      end
      ST_HOLD: begin
        // Leaving HOLD re-runs the WAIT entry test on this same sample so a
        // strobe that starts right after another loses no cycle.
        if (!same) begin
          if (any_low) begin
            cand_load = 1'b1;
            cnt_d     = 8'd1;
            state_d   = ST_COUNT;
          end else begin
            cnt_d   = 8'd0;
            state_d = ST_WAIT;
          end
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT;
      cnt_q      <= 8'd0;
      cand_an_q  <= '1;
      cand_seg_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cand_load) begin
        cand_an_q  <= an_q;
        cand_seg_q <= seg_q;
      end
    end
  end

  assign eval_ok  = eval && single_low && glyph_hit;
  assign eval_bad = eval && !eval_ok;

  // Next shadow/mask if the current sample is accepted. lo is one-hot here.
  always_comb begin
    shadow_nx = shadow_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (lo[i]) begin
        shadow_nx[4*i +: 4] = glyph_nib;
      end
    end
  end

  assign mask_nx    = mask_q | lo;
  assign frame_done = eval_ok && (&mask_nx);

  // Frame completion publishes the shadow including the nibble just decoded,
  // so data, valid and the cleared mask all appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      valid_q <= frame_done;
      err_q   <= eval_bad;
      if (eval_ok) begin
        shadow_q <= shadow_nx;
        if (frame_done) begin
          data_q <= shadow_nx;
          mask_q <= '0;
        end else begin
          mask_q <= mask_nx;
        end
      end
      if (eval_bad && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.valid      = valid_q;
  assign bus.err        = err_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.digit_mask = mask_q;

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

  localparam int DIGITS = 8;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_capture_if #(.DIGITS(DIGITS)) bus();

  seg7_capture #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;

  typedef struct {
    bit          is_frame;
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;
  exp_t exp_q[$];

  // Segment codes (active low, {g..a}) of the hex digits 0..F.
  logic [6:0] glyphs [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: the display is a sequence of per-cycle values; every run
  // of identical non-blank values lasting SETTLE cycles yields one evaluation.
  logic [31:0] m_shadow;
  logic [7:0]  m_mask;
  int          m_errs;
  logic [7:0]  prev_an;
  logic [6:0]  prev_seg;
  int          run;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_shadow = '0;
    m_mask   = '0;
    m_errs   = 0;
    prev_an  = 8'hFF;
    prev_seg = '0;
    run      = 0;
  endtask

  function automatic int decode(input logic [6:0] s);
    for (int k = 0; k < 16; k++) if (glyphs[k] == s) return k;
    return -1;
  endfunction

  task automatic model_eval(input logic [7:0] an, input logic [6:0] seg);
    int lows;
    int d;
    int pos;
    exp_t e;
    lows = 0;
    pos  = 0;
    for (int i = 0; i < DIGITS; i++) if (!an[i]) begin lows++; pos = i; end
    d = decode(seg);
    if (lows != 1 || d < 0) begin
      m_errs++;
      e.is_frame = 1'b0;
      e.data     = '0;
      e.cnt      = (m_errs > 255) ? 8'd255 : 8'(m_errs);
      exp_q.push_back(e);
    end else begin
      m_shadow[4*pos +: 4] = 4'(d);
      m_mask[pos] = 1'b1;
      if (m_mask == 8'hFF) begin
        e.is_frame = 1'b1;
        e.data     = m_shadow;
        e.cnt      = '0;
        exp_q.push_back(e);
        m_mask = '0;
      end
    end
  endtask

  task automatic model_step(input logic [7:0] an, input logic [7:0] cn);
    if (an == 8'hFF) begin
      run = 0;
      prev_an = 8'hFF;
    end else begin
      if (an == prev_an && cn[6:0] == prev_seg) run++;
      else begin
        run = 1;
        prev_an = an;
        prev_seg = cn[6:0];
      end
      if (run == SETTLE) model_eval(an, cn[6:0]);
    end
  endtask

  task automatic cyc(input logic [7:0] an, input logic [7:0] cn);
    bus.anodes = an;
    bus.cnodes = cn;
    model_step(an, cn);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [7:0] an, input logic [7:0] cn, input int n);
    repeat (n) cyc(an, cn);
  endtask

  task automatic blank(input int n);
    hold(8'hFF, 8'hFF, n);
  endtask

  task automatic digit(input int i, input logic [3:0] nib, input int n);
    logic [7:0] an;
    an = ~(8'b1 << i);
    hold(an, {1'b1, glyphs[nib]}, n);
  endtask

  task automatic scan(input logic [31:0] v, input int n);
    for (int i = 0; i < DIGITS; i++) digit(i, v[4*i +: 4], n);
  endtask

  // Blank long enough for all pending outputs, then the scoreboard must be empty.
  task automatic drain(input string name);
    blank(SETTLE + 6);
    chk(name, exp_q.size(), 0);
  endtask

  // Monitor: pops and compares whenever the DUT presents a pulse.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.valid) valid_seen++;
      if (bus.valid) chk("valid_back_to_back", prev_valid, 0);
      if (bus.valid || bus.err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {bus.valid, bus.err}, 0);
        end else begin
          e = exp_q.pop_front();
          if (bus.valid) begin
            chk("valid_kind", e.is_frame, 1);
            chk("frame_data", bus.data, e.data);
            chk("mask_after_valid", bus.digit_mask, 0);
          end else begin
            chk("err_kind", e.is_frame, 0);
            chk("err_cnt", bus.err_cnt, e.cnt);
          end
        end
      end
      prev_valid = bus.valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    logic [31:0] fr;
    logic [7:0]  an;
    logic [7:0]  cn;
    int          mode;
    int          len;

    model_reset();
    bus.anodes = 8'hFF;
    bus.cnodes = 8'hFF;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", bus.data, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_mask", bus.digit_mask, 0);
    rst_n = 1'b1;
    blank(2);

    // Clean scan, 10 cycles per digit.
    scan(32'h1234ABCD, 10);
    drain("t27_drain");
    chk("t27_data", bus.data, 32'h1234ABCD);
    chk("t27_err_cnt", bus.err_cnt, 0);
    chk("t27_valid_count", valid_seen, 1);

    // Blank gaps and a one-cycle glyph-8 glitch between digits.
    for (int i = 0; i < DIGITS; i++) begin
      fr = 32'h1234ABCD;
      digit(i, fr[4*i +: 4], 10);
      an = ~(8'b1 << i);
      cyc(an, 8'h80);
      blank(2);
    end
    drain("t28_drain");
    chk("t28_data", bus.data, 32'h1234ABCD);
    chk("t28_err_cnt", bus.err_cnt, 0);

    // Digit 3 blank glyph is rejected; frame completes only once it is resent.
    v0 = valid_seen;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == 3) hold(8'hF7, 8'hFF, 10);
      else digit(i, 4'(i + 5), 10);
      blank(1);
    end
    drain("t29_drain");
    chk("t29_err_cnt", bus.err_cnt, 1);
    chk("t29_mask", bus.digit_mask, 8'hF7);
    chk("t29_no_valid", valid_seen - v0, 0);
    digit(3, 4'h8, 10);
    drain("t29_drain2");
    chk("t29_data", bus.data, 32'hCBA98765 & 32'hFFFF_0FFF | 32'h0000_8000);
    chk("t29_valid_count", valid_seen - v0, 1);

    // Strobes one cycle short of SETTLE are ignored; exactly SETTLE is accepted.
    scan(32'h5A5A5A5A, SETTLE - 1);
    drain("short_drain");
    chk("short_mask", bus.digit_mask, 0);
    scan(32'h0567F0E9, SETTLE);
    drain("exact_drain");
    chk("exact_data", bus.data, 32'h0567F0E9);

    // Two back-to-back frames.
    v0 = valid_seen;
    scan(32'h11111111, 10);
    blank(1);
    scan(32'h89ABCDEF, 10);
    drain("t32_drain");
    chk("t32_valid_count", valid_seen - v0, 2);
    chk("t32_data", bus.data, 32'h89ABCDEF);
    chk("t32_mask", bus.digit_mask, 0);

    // Randomized strobes: good digits, bad glyphs, double anodes, glitches.
    for (int f = 0; f < 30; f++) begin
      fr = $urandom;
      for (int i = 0; i < DIGITS; i++) begin
        mode = $urandom_range(0, 7);
        len  = $urandom_range(1, 12);
        an   = ~(8'b1 << i);
        cn   = {1'b1, glyphs[fr[4*i +: 4]]};
        if (mode == 0) cn = 8'($urandom);
        else if (mode == 1) an = ~((8'b1 << i) | (8'b1 << ((i + 1) % DIGITS)));
        if (mode == 2) cyc(an, 8'($urandom));
        hold(an, cn, len);
        blank($urandom_range(0, 2));
      end
    end
    drain("rand_drain");

    // Double-anode strobes saturate the error counter.
    for (int k = 0; k < 300; k++) begin
      hold(8'hFC, 8'hC0, 10);
      blank(2);
    end
    drain("t30_drain");
    chk("t30_err_cnt_sat", bus.err_cnt, 255);

    // Reset mid-frame drops the partial frame.
    for (int i = 0; i < 5; i++) digit(i, 4'hF, 10);
    drain("t31_pre_drain");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    chk("t31_rst_data", bus.data, 0);
    chk("t31_rst_mask", bus.digit_mask, 0);
    chk("t31_rst_err_cnt", bus.err_cnt, 0);
    v0 = valid_seen;
    scan(32'h00000042, 10);
    drain("t31_drain");
    chk("t31_data", bus.data, 32'h00000042);
    chk("t31_valid_count", valid_seen - v0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
